// File: rtl/pipe_scheduler.sv
// Pipe obstacle controller: fixed slot pool, frame-scheduled spawns with LFSR gaps,
// scroll/retire per frame, serialized score pulses and progressive scroll speed.
module pipe_slot #(
  parameter int SCREEN_W = 640,
  parameter int PIPE_W   = 52,
  parameter int BIRD_X   = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        tick,
  input  logic        spawn,
  input  logic [2:0]  speed,
  input  logic [8:0]  gap_in,
  output logic        valid,
  output logic [10:0] xr,
  output logic [8:0]  gap,
  output logic        retire,
  output logic        pass
);
  localparam logic [10:0] XR_SPAWN = 11'(SCREEN_W + PIPE_W);
  localparam logic [10:0] XR_BIRD  = 11'(BIRD_X);

  logic        passed;
  logic [10:0] xr_sub;

  // A pipe retired this tick has necessarily crossed the bird, so it still scores.
  always_comb begin
    xr_sub = xr - {8'd0, speed};
    retire = valid && (xr <= {8'd0, speed});
    pass   = tick && valid && !passed && (retire || (xr_sub < XR_BIRD));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      valid  <= 1'b0;
      xr     <= '0;
      gap    <= '0;
      passed <= 1'b0;
    end else if (tick) begin
      if (spawn) begin
        valid  <= 1'b1;
        xr     <= XR_SPAWN;
        gap    <= gap_in;
        passed <= 1'b0;
      end else if (retire) begin
        valid  <= 1'b0;
        passed <= 1'b0;
      end else if (valid) begin
        xr <= xr_sub;
        if (pass) passed <= 1'b1;
      end
    end
  end
endmodule

module pipe_scheduler #(
  parameter int          NUM_PIPES     = 3,
  parameter int          SCREEN_W      = 640,
  parameter int          PIPE_W        = 52,
  parameter int          BIRD_X        = 160,
  parameter int          SPAWN_FRAMES  = 90,
  parameter int          GAP_MIN       = 60,
  parameter int          GAP_SPAN      = 200,
  parameter int          SPEED_INIT    = 2,
  parameter int          SPEED_MAX     = 6,
  parameter int          SPEEDUP_EVERY = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               state,
  input  logic                     frame_tick,
  output logic [NUM_PIPES-1:0]     pipe_valid,
  output logic [11*NUM_PIPES-1:0]  pipe_xr,
  output logic [9*NUM_PIPES-1:0]   pipe_gap,
  output logic                     score_pulse,
  output logic [2:0]               speed,
  output logic                     spawn_drop
);
  localparam int SCW = $clog2(SPAWN_FRAMES + 1);
  localparam int PCW = $clog2(SPEEDUP_EVERY + 1);

  logic                          play, idle, tick, spawn_now, any_free, emit;
  logic [15:0]                   lfsr;
  logic [SCW-1:0]                spawn_cnt;
  logic [PCW-1:0]                pass_cnt;
  logic [2:0]                    pending, n_inc;
  logic [3:0]                    pend_sum, pend_next;
  logic [7:0]                    b, b_fold;
  logic [8:0]                    gap_new;
  logic [NUM_PIPES-1:0]          retire, pass, spawn_vec;
  logic [NUM_PIPES-1:0][10:0]    xr_a;
  logic [NUM_PIPES-1:0][8:0]     gap_a;

  assign play      = (state == 2'd1);
  assign idle      = (state == 2'd0) || (state == 2'd3);
  assign tick      = play && frame_tick;
  assign spawn_now = tick && (spawn_cnt == SCW'(SPAWN_FRAMES - 1));
  assign pipe_xr   = xr_a;
  assign pipe_gap  = gap_a;

  // Fold out-of-range LFSR bytes back into 0..GAP_SPAN.
  assign b       = lfsr[7:0];
  assign b_fold  = (b > 8'(GAP_SPAN)) ? b - 8'(GAP_SPAN + 1) : b;
  assign gap_new = 9'(GAP_MIN) + {1'b0, b_fold};

  always_comb begin
    spawn_vec = '0;
    any_free  = 1'b0;
    n_inc     = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (!any_free && (!pipe_valid[i] || retire[i])) begin
        spawn_vec[i] = spawn_now;
        any_free     = 1'b1;
      end
      n_inc = n_inc + {2'd0, pass[i]};
    end
  end

  // Passes from this tick can drive the pulse directly; score_pulse gating keeps a low gap.
  always_comb begin
    pend_sum  = {1'b0, pending} + {1'b0, n_inc};
    emit      = play && !score_pulse && (pend_sum != 4'd0);
    pend_next = pend_sum - {3'd0, emit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || idle) begin
      spawn_cnt   <= SCW'(SPAWN_FRAMES - 1);
      pending     <= '0;
      pass_cnt    <= '0;
      score_pulse <= 1'b0;
      speed       <= 3'(SPEED_INIT);
      spawn_drop  <= 1'b0;
    end else if (!play) begin
      pending     <= '0;
      score_pulse <= 1'b0;
    end else begin
      if (tick) begin
        spawn_cnt <= spawn_now ? '0 : spawn_cnt + SCW'(1);
        if (spawn_now && !any_free) spawn_drop <= 1'b1;
      end
      score_pulse <= emit;
      pending     <= (pend_next > 4'd7) ? 3'd7 : pend_next[2:0];
      if (emit) begin
        if (pass_cnt == PCW'(SPEEDUP_EVERY - 1)) begin
          pass_cnt <= '0;
          if (speed < 3'(SPEED_MAX)) speed <= speed + 3'd1;
        end else begin
          pass_cnt <= pass_cnt + PCW'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
    pipe_slot #(
      .SCREEN_W(SCREEN_W),
      .PIPE_W  (PIPE_W),
      .BIRD_X  (BIRD_X)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (idle),
      .tick  (tick),
      .spawn (spawn_vec[i]),
      .speed (speed),
      .gap_in(gap_new),
      .valid (pipe_valid[i]),
      .xr    (xr_a[i]),
      .gap   (gap_a[i]),
      .retire(retire[i]),
      .pass  (pass[i])
    );
  end
endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: spawn schedule, pass scoring, retire/reuse,
// drop flag, OVER freeze, IDLE clear, speed ramp and mid-play reset.
module tb_pipe_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0;
  logic [1:0]  state = 2'd0;
  logic [2:0]  pipe_valid;
  logic [32:0] pipe_xr;
  logic [26:0] pipe_gap;
  logic        score_pulse, spawn_drop;
  logic [2:0]  speed;

  int n_vec = 0, n_err = 0;
  int n_pass = 0, pass_base = 0, spd_bad = 0, sep_bad = 0;
  logic        prev_pulse = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [8:0]  gap_exp = '0;

  always #5 clk = ~clk;

  pipe_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .frame_tick (frame_tick),
    .pipe_valid (pipe_valid),
    .pipe_xr    (pipe_xr),
    .pipe_gap   (pipe_gap),
    .score_pulse(score_pulse),
    .speed      (speed),
    .spawn_drop (spawn_drop)
  );

  always @(posedge clk)
    m_lfsr <= !rst_n ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  function automatic int exp_speed(int k);
    return (2 + k / 10 > 6) ? 6 : 2 + k / 10;
  endfunction

  function automatic int xr(int i);
    return int'(pipe_xr[11*i +: 11]);
  endfunction

  function automatic int gp(int i);
    return int'(pipe_gap[9*i +: 9]);
  endfunction

  // Pulse monitor: counts passes, flags back-to-back pulses and wrong speed at each pulse.
  always @(negedge clk) begin
    if (score_pulse) begin
      n_pass <= n_pass + 1;
      if (int'(speed) != exp_speed(n_pass + 1 - pass_base)) spd_bad <= spd_bad + 1;
      if (prev_pulse) sep_bad <= sep_bad + 1;
    end
    prev_pulse <= score_pulse;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_tick();
    logic [7:0] b;
    @(negedge clk);
    frame_tick = 1'b1;
    b = m_lfsr[7:0];
    if (b > 8'd200) b = b - 8'd201;
    gap_exp = 9'd60 + {1'b0, b};
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(pipe_valid), 0);
    chk("rst_xr",    int'(pipe_xr), 0);
    chk("rst_gap",   int'(pipe_gap), 0);
    chk("rst_pulse", int'(score_pulse), 0);
    chk("rst_speed", int'(speed), 2);
    chk("rst_drop",  int'(spawn_drop), 0);

    // Tick 1 right after reset: LFSR=ACE1, byte E1=225 folds to 24, gap 84.
    rst_n = 1'b1; state = 2'd1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("t1_valid", int'(pipe_valid), 1);
    chk("t1_xr0",   xr(0), 692);
    chk("t1_gap0",  gp(0), 84);
    chk("t1_speed", int'(speed), 2);

    repeat (89) do_tick();                       // ticks 2..90
    chk("t90_valid", int'(pipe_valid), 1);
    chk("t90_xr0",   xr(0), 514);
    do_tick();                                   // tick 91
    chk("t91_valid", int'(pipe_valid), 3);
    chk("t91_xr0",   xr(0), 512);
    chk("t91_xr1",   xr(1), 692);
    chk("t91_gap1",  gp(1), int'(gap_exp));

    repeat (176) do_tick();                      // ticks 92..267
    chk("t267_xr0",   xr(0), 160);
    chk("t267_npass", n_pass, 0);
    chk("t267_pulse", int'(score_pulse), 0);
    do_tick();                                   // tick 268: 160 -> 158
    chk("t268_pulse", int'(score_pulse), 1);
    chk("t268_xr0",   xr(0), 158);
    @(negedge clk);
    chk("t268_pulse_low", int'(score_pulse), 0);
    chk("t268_npass",     n_pass, 1);

    repeat (3) do_tick();                        // ticks 269..271: 4th spawn has no slot
    chk("t271_drop",  int'(spawn_drop), 1);
    chk("t271_valid", int'(pipe_valid), 7);
    chk("t271_xr0",   xr(0), 152);
    chk("t271_xr1",   xr(1), 332);
    chk("t271_xr2",   xr(2), 512);

    repeat (75) do_tick();                       // ticks 272..346
    chk("t346_xr0",   xr(0), 2);
    chk("t346_valid", int'(pipe_valid), 7);
    do_tick();                                   // tick 347: xr0 <= speed, retire
    chk("t347_valid", int'(pipe_valid), 6);
    chk("t347_drop",  int'(spawn_drop), 1);
    repeat (14) do_tick();                       // ticks 348..361: slot0 reused
    chk("t361_valid", int'(pipe_valid), 7);
    chk("t361_xr0",   xr(0), 692);
    chk("t361_gap0",  gp(0), int'(gap_exp));
    chk("t361_xr1",   xr(1), 152);
    chk("t361_xr2",   xr(2), 332);
    chk("t361_npass", n_pass, 2);
    chk("t361_speed", int'(speed), 2);

    @(negedge clk); state = 2'd2;                // OVER: ticks ignored
    repeat (3) do_tick();
    chk("over_valid", int'(pipe_valid), 7);
    chk("over_xr0",   xr(0), 692);
    chk("over_xr1",   xr(1), 152);
    chk("over_xr2",   xr(2), 332);
    chk("over_drop",  int'(spawn_drop), 1);
    chk("over_pulse", int'(score_pulse), 0);

    @(negedge clk); state = 2'd0;                // IDLE clears next cycle
    @(negedge clk);
    chk("idle_valid", int'(pipe_valid), 0);
    chk("idle_xr",    int'(pipe_xr), 0);
    chk("idle_gap",   int'(pipe_gap), 0);
    chk("idle_drop",  int'(spawn_drop), 0);
    chk("idle_speed", int'(speed), 2);
    pass_base = n_pass;

    @(negedge clk); state = 2'd1;                // long run for speed ramp
    t = 0;
    while ((n_pass - pass_base) < 42 && t < 8000) begin
      do_tick();
      t++;
    end
    chk("ramp_done",  int'((n_pass - pass_base) >= 42), 1);
    chk("ramp_speed", int'(speed), 6);
    chk("ramp_spd_at_pulse", spd_bad, 0);
    chk("pulse_separation",  sep_bad, 0);

    @(negedge clk); rst_n = 1'b0; frame_tick = 1'b1; // reset beats a tick
    @(negedge clk); frame_tick = 1'b0;
    chk("mrst_valid", int'(pipe_valid), 0);
    chk("mrst_xr",    int'(pipe_xr), 0);
    chk("mrst_gap",   int'(pipe_gap), 0);
    chk("mrst_pulse", int'(score_pulse), 0);
    chk("mrst_speed", int'(speed), 2);
    chk("mrst_drop",  int'(spawn_drop), 0);
    rst_n = 1'b1; frame_tick = 1'b1;             // LFSR back at seed -> gap 84
    @(negedge clk); frame_tick = 1'b0;
    chk("mrst_t1_valid", int'(pipe_valid), 1);
    chk("mrst_t1_xr0",   xr(0), 692);
    chk("mrst_t1_gap0",  gp(0), 84);
    chk("mrst_t1_pulse", int'(score_pulse), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
Controller for the pipe-obstacle resource of the flappy game. Owns a fixed pool of pipe slots and spawns pipes into free slots on a frame-based schedule. Gap heights come from an LFSR. On each frame tick it scrolls every live pipe left and retires pipes that leave the screen. Emits one score_pulse per pipe passed and raises scroll speed with progress. It is driven by the game state machine's state output and feeds the renderer and the collision checker.

Parameters:
NUM_PIPES, 3, number of pipe slots (1..4)
SCREEN_W, 640, screen width in pixels
PIPE_W, 52, pipe width in pixels
BIRD_X, 160, bird x position in pixels; a pipe is passed when its right edge goes below this
SPAWN_FRAMES, 90, frame ticks between spawns
GAP_MIN, 60, minimum gap top y
GAP_SPAN, 200, gap top range; gap_top is in GAP_MIN..GAP_MIN+GAP_SPAN
SPEED_INIT, 2, initial scroll speed in px per frame
SPEED_MAX, 6, speed ceiling
SPEEDUP_EVERY, 10, number of passes per speed increment
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
state  in  2  game state: 0=IDLE, 1=PLAY, 2=OVER, 3 treated as IDLE
frame_tick  in  1  one-cycle pulse per video frame
pipe_valid  out  NUM_PIPES  slot i is live
pipe_xr  out  11*NUM_PIPES  right-edge x of slot i (left edge = pipe_xr-PIPE_W); slot i at bits [11i+10:11i]
pipe_gap  out  9*NUM_PIPES  gap top y of slot i
score_pulse  out  1  one-cycle pulse per pipe passed
speed  out  3  current scroll speed
spawn_drop  out  1  sticky flag: a spawn was dropped because no slot was free

Behaviour:
- Reset (rst_n=0 at posedge): pipe_valid=0, pipe_xr=0, pipe_gap=0, score_pulse=0, speed=SPEED_INIT, spawn_drop=0, passed bits=0, pass counter=0, pending=0, spawn counter=SPAWN_FRAMES-1, LFSR=LFSR_SEED. Reset takes priority over every other event.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle when not in reset, regardless of state.
- IDLE (state 0 or 3): every cycle, perform all reset actions except the LFSR. Pipes disappear one cycle after state enters IDLE.
- OVER (state 2): freeze all registers, so pipes stay visible. frame_tick is ignored. Any pending score pulses are discarded.
- PLAY (state 1), on a cycle where frame_tick=1; all effects are registered and visible the next cycle:
  - Retire/scroll, for each valid slot: if pipe_xr <= speed, clear valid and passed; else pipe_xr -= speed.
  - Pass detection: a slot that is valid, not yet passed, and whose new pipe_xr < BIRD_X sets passed and adds 1 to pending. A slot retired in the same tick still counts if it was not yet passed.
  - Spawn: if spawn counter = SPAWN_FRAMES-1, reset it to 0 and spawn; else increment it.
    - Spawn target is the lowest-index slot that is invalid after this tick's retire step. It gets valid=1, pipe_xr=SCREEN_W+PIPE_W, passed=0.
    - pipe_gap = GAP_MIN + b, where b = lfsr[7:0]; if b > GAP_SPAN, use b-GAP_SPAN-1 instead of b.
    - If no slot is free, spawn_drop is set and stays set until reset or IDLE.
  - The first PLAY frame_tick therefore spawns immediately.
- score_pulse serialization:
  - pending is a 3-bit counter.
  - While pending>0 and in PLAY, assert score_pulse for one cycle and decrement pending.
  - Pulses are separated by at least one low cycle.
  - Increments and a decrement in the same cycle combine arithmetically.
- Speed:
  - Pass counter counts emitted score pulses, 0..SPEEDUP_EVERY-1.
  - On wrap, speed = min(speed+1, SPEED_MAX).
  - A speed change applies from the next frame_tick.
- Width rules:
  - pipe_xr is 11 bits; the maximum value SCREEN_W+PIPE_W=692 fits.
  - The subtraction never underflows because of the retire rule.
  - pipe_gap is 9 bits; GAP_MIN+GAP_SPAN <= 511.
- frame_tick is a single-cycle pulse. A frame_tick that coincides with a state change is processed according to the state sampled in that cycle.

Test Plan:
- Reset, then state=PLAY and one frame_tick -> next cycle pipe_valid=3'b001, pipe_xr[0]=692, pipe_gap[0] in 60..260, speed=2.
- PLAY with 90 ticks -> slot1 spawns at 692 on tick 91. Slot0 pipe_xr=692-2*90=512 after tick 91.
- Continue until slot0 pipe_xr goes from 160 to 158 -> exactly one score_pulse, one cycle wide, 1 cycle after that tick. No further pulse from slot0.
- Run through 10 passes -> speed goes 2->3 and saturates at 6 after 40 passes. Slot0 retires when pipe_xr <= speed, and its freed slot is reused by the next spawn.
- SPAWN_FRAMES=1 with 3 slots so all slots fill -> spawn_drop=1 and stays 1. OVER freezes all outputs across ticks. IDLE clears valid and spawn_drop next cycle.
- rst_n low mid-PLAY with pending=2 -> next cycle all outputs take reset values, no score_pulse, LFSR=16'hACE1.
